// File: rtl/lcd_msg_arbiter.sv
// Round-robin arbiter that shares one character-LCD display controller between
// NREQ message sources: grant, one-cycle start/set, wait for done or watchdog, ack.
module lcd_msg_arbiter #(
  parameter int              NREQ    = 3,
  parameter int              VAL_W   = 16,
  parameter int              TO_W    = 28,
  parameter logic [TO_W-1:0] TIMEOUT = 28'd200_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [2*NREQ-1:0]     req_mode,
  input  logic [VAL_W*NREQ-1:0] req_value,
  output logic [NREQ-1:0]       ack,
  output logic                  busy,
  output logic                  disp_start,
  output logic                  disp_set,
  output logic [1:0]            disp_mode,
  output logic [VAL_W-1:0]      disp_value,
  input  logic                  disp_done,
  output logic                  timeout_err
);

  localparam int              IDX_W    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int              CW       = IDX_W + 1;
  localparam logic [CW-1:0]   NREQ_C   = CW'(NREQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREQ - 1);
  localparam logic [TO_W-1:0] TO_LAST  = TIMEOUT - {{(TO_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  state_t            state, state_n;
  logic [IDX_W-1:0]  grant, grant_n;
  logic [IDX_W-1:0]  ptr, ptr_n;
  logic [TO_W-1:0]   wd, wd_n;
  logic [NREQ-1:0]   ack_n;
  logic              busy_n;
  logic              start_n;
  logic              set_n;
  logic [1:0]        mode_n;
  logic [VAL_W-1:0]  value_n;
  logic              terr_n;

  logic [1:0]        mode_slot  [NREQ];
  logic [VAL_W-1:0]  value_slot [NREQ];
  logic [CW-1:0]     scan_sum   [NREQ];
  logic [IDX_W-1:0]  scan_idx   [NREQ];
  logic              pick_found;
  logic [IDX_W-1:0]  pick_idx;

  for (genvar i = 0; i < NREQ; i++) begin : g_slot
    assign mode_slot[i]  = req_mode[2*i +: 2];
    assign value_slot[i] = req_value[VAL_W*i +: VAL_W];
  end

  // Scan from the pointer upward with wrap; the first requester found wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_sum[k] = {1'b0, ptr} + CW'(k);
      scan_idx[k] = (scan_sum[k] >= NREQ_C) ? IDX_W'(scan_sum[k] - NREQ_C)
                                            : scan_sum[k][IDX_W-1:0];
      if (!pick_found && req[scan_idx[k]]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx[k];
      end
    end
  end

  always_comb begin
    state_n = state;
    grant_n = grant;
    ptr_n   = ptr;
    wd_n    = wd;
    ack_n   = '0;
    busy_n  = busy;
    start_n = 1'b0;
    set_n   = 1'b0;
    mode_n  = disp_mode;
    value_n = disp_value;
    terr_n  = 1'b0;

    case (state)
      IDLE: begin
        busy_n = 1'b0;
        if (pick_found) begin
          grant_n = pick_idx;
          mode_n  = mode_slot[pick_idx];
          value_n = value_slot[pick_idx];
          busy_n  = 1'b1;
          start_n = 1'b1;
          set_n   = 1'b1;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        wd_n    = '0;
        state_n = WAIT;
      end
      // A done pulse takes priority over a watchdog expiry in the same cycle.
      WAIT: begin
        wd_n = wd + {{(TO_W-1){1'b0}}, 1'b1};
        if (disp_done) begin
          ack_n[grant] = 1'b1;
          state_n      = ACK;
        end else if (wd == TO_LAST) begin
          ack_n[grant] = 1'b1;
          terr_n       = 1'b1;
          state_n      = ACK;
        end
      end
      ACK: begin
        ptr_n   = (grant == LAST_IDX) ? '0 : grant + IDX_W'(1);
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      grant       <= '0;
      ptr         <= '0;
      wd          <= '0;
      ack         <= '0;
      busy        <= 1'b0;
      disp_start  <= 1'b0;
      disp_set    <= 1'b0;
      disp_mode   <= '0;
      disp_value  <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      grant       <= grant_n;
      ptr         <= ptr_n;
      wd          <= wd_n;
      ack         <= ack_n;
      busy        <= busy_n;
      disp_start  <= start_n;
      disp_set    <= set_n;
      disp_mode   <= mode_n;
      disp_value  <= value_n;
      timeout_err <= terr_n;
    end
  end

  a_ack_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(ack));
  a_idle_quiet: assert property (@(posedge clk) disable iff (!rst)
                                 (state == IDLE) |-> (ack == '0 && !busy));

endmodule

// File: doc/lcd_msg_arbiter.md
Name: lcd_msg_arbiter

Overview:
- Shares the single SPI character-LCD display controller (start/set/mode/value handshake) between NREQ independent message sources, e.g. the countdown core, the guess checker and the answer-set logic.
- Arbitrates round-robin, latches the winner's mode and value, and issues one display transaction.
- Waits for the controller's completion pulse, or a watchdog timeout, then acknowledges the requester.
- Sits between the game logic and the display FSM.

Parameters:
NREQ, 3, number of requesters (2..8)
VAL_W, 16, width of displayed value (four BCD/hex digits)
TO_W, 28, watchdog counter width
TIMEOUT, 28'd200_000_000, WAIT cycles before forced completion (must exceed the display hold delay)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-low reset (rst==0 resets on the clock edge)
req  input  NREQ  level request per source, held until ack
req_mode  input  2*NREQ  packed display mode per source (0 normal, 1 congrat, 2 value set, 3 guess again), slot i = [2i+1:2i]
req_value  input  VAL_W*NREQ  packed value per source, slot i = [VAL_W*(i+1)-1:VAL_W*i]
ack  output  NREQ  one-cycle pulse to the served source at completion
busy  output  1  high from grant through ACK
disp_start  output  1  to display controller start
disp_set  output  1  to display controller set
disp_mode  output  2  latched mode of current grant
disp_value  output  VAL_W  latched value of current grant
disp_done  input  1  one-cycle completion pulse from the display controller (its finish state)
timeout_err  output  1  one-cycle pulse with ack when completion was forced by the watchdog

Behaviour:
- All outputs are registered. Reset (rst==0): state IDLE, ack=0, busy=0, disp_start=0, disp_set=0, disp_mode=0, disp_value=0, timeout_err=0, rr pointer=0, watchdog=0.
- States: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - If any req bit is set, select the first set bit scanning from the pointer upward with wrap (pointer, pointer+1, ..., NREQ-1, 0, ...).
  - Latch grant index, disp_mode and disp_value from that slot; busy<=1; go to ISSUE.
  - If no req bit is set, stay in IDLE.
- ISSUE:
  - disp_start=disp_set=1 for exactly this one cycle; watchdog cleared; go to WAIT.
  - Latency: req sampled in cycle n gives disp_start high in cycle n+1.
- WAIT:
  - disp_start=disp_set=0; watchdog increments each cycle.
  - If disp_done=1, go to ACK with err=0.
  - Else if watchdog==TIMEOUT-1, go to ACK with err=1.
  - disp_done and timeout in the same cycle: done wins, err=0.
- ACK:
  - ack[grant]=1 and timeout_err=err for this cycle only.
  - pointer <= grant+1, wrapping to 0 at NREQ.
  - Go to IDLE; busy=0 from the IDLE cycle onward.
- disp_mode and disp_value hold stable from ISSUE through ACK and keep their last value in IDLE until the next grant.
- Requester rule: deassert req in the cycle after seeing ack. IDLE after ACK then samples the dropped request; a still-high req is a new request.
- Changes to req, req_mode or req_value after a grant do not affect the in-flight transaction. A withdrawn req still completes and is acked.
- disp_done outside WAIT is ignored.
- Reset mid-transaction: state IDLE next edge, no ack, no timeout_err, pointer=0.
- At most one ack bit is high in any cycle; ack and busy are never both high in IDLE.

Test Plan:
1. Single request: after reset, req=3'b001, mode0=1, value0=16'h1234; disp_done pulsed 10 cycles after disp_start -> disp_start/disp_set high exactly 1 cycle (cycle after req); disp_mode=1, disp_value=16'h1234; ack=3'b001 one cycle after done; timeout_err=0; busy low the following cycle.
2. Fairness and wrap: req=3'b111 held and re-asserted after each ack, done returned each time -> grant order 0,1,2,0,1,2; each ack a single-cycle pulse.
3. Pointer skip: pointer=1 after serving source 0, then req=3'b101 -> source 2 is granted before source 0.
4. Watchdog: TIMEOUT=50, req=3'b010, disp_done never pulsed -> ack=3'b010 and timeout_err=1 in the same cycle, exactly 51 cycles after the ISSUE cycle; next request still served normally.
5. Coincident events: TIMEOUT=50 with disp_done pulsed on the 50th WAIT cycle -> ack asserted, timeout_err=0. Also disp_done pulsed during IDLE -> no effect.
6. Reset during WAIT: rst=0 for one edge -> busy=0, disp_mode=0, disp_value=0, no ack; a following req=3'b100 is served with the pointer starting from 0.
